// File: rtl/mux_pkg.sv
// Shared definitions for the channel multiplexer/arbiter: mode encodings
// and the ceil-log2 helper used to size channel indices.
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Ceiling log2, minimum 1 so a select port is never zero-width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: scans the request vector upward from
// ptr+1 (wrapping) and returns the first requester as one-hot and index.
module rr_grant
    import mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] idx,
    output logic            any
);

    // First requester after ptr wins; NCH is a power of two so the
    // SELW-bit addition wraps modulo NCH on its own.
    always_comb begin
        logic [SELW-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < NCH; off++) begin
            cand = ptr + SELW'(off + 1);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mux_arb_rr.sv
// N-channel to one multiplexer with fixed-select or round-robin arbitration
// and a single registered output stage with valid/ready handshake.
module mux_arb_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int NCH   = 4,
    localparam int SELW = clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    mode_e           mode_q;
    logic            can_load;
    logic            transfer;
    logic [SELW-1:0] ptr;
    logic [NCH-1:0]  rr_gnt;
    logic [SELW-1:0] rr_idx;
    logic            rr_any;
    logic [SELW-1:0] sel_idx;
    logic [WIDTH-1:0] sel_data;

    assign mode_q   = mode_e'(mode);
    assign can_load = !out_valid || out_ready;
    assign transfer = |(in_valid & in_ready);

    rr_grant #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_grant (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (rr_gnt),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // Per-channel accept: one bit at most, and none while held in reset.
    always_comb begin
        in_ready = '0;
        sel_idx  = sel;
        if (mode_q == MODE_RR) begin
            sel_idx = rr_idx;
            if (rst_n && can_load && rr_any) begin
                in_ready = rr_gnt;
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                in_ready[k] = rst_n && can_load && (SELW'(k) == sel);
            end
        end
    end

    // Data of the channel being granted this cycle.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (SELW'(k) == sel_idx) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer; ptr starts at NCH-1 so
    // channel 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '1;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= sel_idx;
            if (mode_q == MODE_RR) begin
                ptr <= rr_idx;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_arb_rr.md
MUX_ARB_RR -- requirements
Module: mux_arb_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 3, data bits per channel (>=1).
REQ-002 SHALL have parameter NCH, default 4, number of input channels (power of 2, 2..16).
REQ-003 SHALL have localparam SELW = clog2(NCH), the select/channel-index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, NCH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid, input, NCH bits: per-channel valid.
REQ-008 SHALL have port in_ready, output, NCH bits: per-channel accept; at most one bit is high per cycle.
REQ-009 SHALL have port mode, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel, input, SELW bits: channel index used when mode=0.
REQ-011 SHALL have port out_data, output, WIDTH bits: registered selected data.
REQ-012 SHALL have port out_ch, output, SELW bits: source channel of out_data.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data holds a word.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-015 SHALL compute can_load = !out_valid || out_ready; a transfer on channel k SHALL occur when in_valid[k] && in_ready[k].
REQ-016 SHALL, in mode=0, drive in_ready[sel] = can_load and all other in_ready bits 0, whatever in_valid is.
REQ-017 SHALL, in mode=1, grant the first valid channel found scanning upward from ptr+1 modulo NCH, with in_ready[grant] = can_load.
REQ-018 SHALL hold a round-robin pointer ptr (SELW bits) that updates to the granted index only on a transfer in mode=1; ptr SHALL be unchanged in mode=0.
REQ-019 SHALL, on a transfer, register out_data = the granted channel's data, out_ch = its index and out_valid = 1 at the next rising edge; latency is 1 cycle.
REQ-020 SHALL clear out_valid on the next edge when out_ready=1 and no transfer occurs; out_data and out_ch SHALL then hold their last values.
REQ-021 SHALL hold out_data, out_ch and out_valid stable while out_valid=1 and out_ready=0, with all in_ready bits 0.
REQ-022 SHALL sustain one word per cycle when out_ready stays 1 (drain and load in the same cycle).
REQ-023 SHALL drive all in_ready bits 0 and leave ptr unchanged when no in_valid is set in mode=1.
REQ-024 SHALL wrap ptr from NCH-1 to 0; with a single requester k, k SHALL be granted on every transfer.
REQ-025 SHALL allow mode or sel to change on any cycle, taking effect the same cycle for grant calculation; a word already in the output register SHALL be unaffected.
REQ-026 SHALL be fully synchronous to clk except for rst_n, and SHALL contain no combinational path from in_data to out_data.

Reset
REQ-027 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_ch=0 and ptr=NCH-1, so that channel 0 has first priority after reset.
REQ-028 SHALL, on reset asserted mid-transfer, discard the held word; in_ready SHALL be 0 while reset is asserted.
REQ-029 SHALL release reset cleanly; the first edge after deassertion can load.

Structure
REQ-030 SHALL place the mode encodings (MODE_FIXED=0, MODE_RR=1) and the clog2 helper in shared package mux_pkg.
REQ-031 SHALL implement the combinational round-robin grant (request vector plus ptr in, one-hot grant and index out) as sub-module rr_grant; fixed-select, the output register and ptr SHALL live in mux_arb_rr.

Verification
REQ-032 SHALL cover: WIDTH=3, NCH=4, mode=0, in_data ch0..3=0,1,2,3, all valid, out_ready=1, sel stepped 0..3 -> out_data 0,1,2,3 and out_ch 0..3, each one cycle after sel.
REQ-033 SHALL cover: mode=1, all four valid, out_ready=1 from reset -> out_ch sequence 0,1,2,3,0, with one-hot in_ready each cycle.
REQ-034 SHALL cover: mode=1, only in_valid[2] set -> out_ch=2 on every word; ptr stays 2.
REQ-035 SHALL cover: out_ready=0 for 3 cycles with out_valid=1, out_data=5 -> output stable at 5, in_ready=0; out_ready=1 -> next word on the following edge.
REQ-036 SHALL cover: rst_n pulsed low mid-stream -> out_valid=0 immediately (asynchronously); after release, first round-robin grant goes to ch0.
